dino_jump_ctrl: RTL and testbench

DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

---
 rtl/dino_pkg.sv | 28 ++
 rtl/btn_edge_sync.sv | 44 ++++
 rtl/dino_jump_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared definitions for the dino sprite: motion state encoding and default
// motion constants. Also consumed by the VGA controller and the collision logic.
package dino_pkg;

    // Motion state of the sprite. GROUND is the only non-airborne state.
    typedef enum logic [1:0] {
        StGround = 2'd0,
        StRise   = 2'd1,
        StHold   = 2'd2,
        StFall   = 2'd3
    } dino_state_e;

    // Default motion constants (rows / frames).
    localparam int unsigned DefGroundY     = 400;
    localparam int unsigned DefJumpHeight  = 120;
    localparam int unsigned DefRiseStep    = 6;
    localparam int unsigned DefFallStep    = 4;
    localparam int unsigned DefHoldFrames  = 8;

    // Width of the y output and of the internal y arithmetic (one spare bit).
    localparam int unsigned YWidth     = 12;
    localparam int unsigned YCalcWidth = 13;

    function automatic logic is_airborne(dino_state_e s);
        return s != StGround;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a raw push button followed by a rising-edge detector.
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   async_in   : raw asynchronous button level (high = pressed)
//   rise_pulse : one-clk pulse on each synchronized 0 -> 1 transition
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic [1:0] fill_q,  fill_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        // fill_q tracks when sync2_q holds a genuinely sampled value after reset.
        fill_d  = {fill_q[0], 1'b1};
        // History only starts following the input once the synchronizer is full,
        // so a button already held at reset release never looks like an edge.
        prev_d  = fill_q[1] ? sync2_q : prev_q;
    end

    assign rise_pulse = fill_q[1] & sync2_q & ~prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: rtl/dino_jump_ctrl.sv
// Jump controller for the dino sprite. Advances a GROUND/RISE/HOLD/FALL motion
// once per enabled frame tick and publishes the sprite bottom row.
//   clk         : 100 MHz system clock
//   reset       : asynchronous, active-low reset
//   screen_end  : one-clk pulse per frame from the VGA timing generator
//   jump_btn    : raw asynchronous push button, high = pressed
//   enable      : high = game running; low freezes motion and frame count
//   y_bottom    : registered sprite bottom row
//   airborne    : high while in RISE, HOLD or FALL
//   frame_count : number of enabled frame ticks, wraps at 2^32
module dino_jump_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned GROUND_Y    = DefGroundY,
    parameter int unsigned JUMP_HEIGHT = DefJumpHeight,
    parameter int unsigned RISE_STEP   = DefRiseStep,
    parameter int unsigned FALL_STEP   = DefFallStep,
    parameter int unsigned HOLD_FRAMES = DefHoldFrames
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                screen_end,
    input  logic                jump_btn,
    input  logic                enable,
    output logic [YWidth-1:0]   y_bottom,
    output logic                airborne,
    output logic [31:0]         frame_count
);

    localparam int unsigned HoldWidth = 16;
    localparam int unsigned ApexY =
        (JUMP_HEIGHT > GROUND_Y) ? 0 : GROUND_Y - JUMP_HEIGHT;

    localparam logic signed [YCalcWidth-1:0] GroundS = YCalcWidth'(GROUND_Y);
    localparam logic signed [YCalcWidth-1:0] ApexS   = YCalcWidth'(ApexY);
    localparam logic signed [YCalcWidth-1:0] RiseS   = YCalcWidth'(RISE_STEP);
    localparam logic signed [YCalcWidth-1:0] FallS   = YCalcWidth'(FALL_STEP);
    localparam logic signed [YCalcWidth-1:0] FirstS  = GroundS - RiseS;

    localparam logic [YWidth-1:0] GroundY12 = YWidth'(GROUND_Y);
    localparam logic [YWidth-1:0] ApexY12   = YWidth'(ApexY);
    // First rise step out of GROUND, clamped so a huge step cannot pass the apex.
    localparam logic [YWidth-1:0] FirstY12  =
        (FirstS <= ApexS) ? ApexY12 : YWidth'(FirstS);
    localparam logic [HoldWidth-1:0] HoldLoad =
        (HOLD_FRAMES == 0) ? 16'd0 : HoldWidth'(HOLD_FRAMES - 1);

    dino_state_e                   state_q, state_d;
    logic [YWidth-1:0]             y_q, y_d;
    logic [HoldWidth-1:0]          hold_q, hold_d;
    logic                          pending_q, pending_d;
    logic [31:0]                   fc_q, fc_d;

    logic                          tick;
    logic                          rise_pulse;
    logic signed [YCalcWidth-1:0]  y_ext, y_up, y_dn;

    btn_edge_sync u_btn_edge_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (jump_btn),
        .rise_pulse (rise_pulse)
    );

    assign tick  = screen_end & enable;
    assign y_ext = $signed({1'b0, y_q});
    assign y_up  = y_ext - RiseS;
    assign y_dn  = y_ext + FallS;

    // State register and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StGround;
            y_q       <= GroundY12;
            hold_q    <= '0;
            pending_q <= 1'b0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            fc_q      <= fc_d;
        end
    end

    // Next-state logic: motion only advances on an enabled frame tick.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        hold_d  = hold_q;
        if (tick) begin
            unique case (state_q)
                StGround: begin
                    if (pending_q) begin
                        state_d = StRise;
                        y_d     = FirstY12;
                    end
                end
                StRise: begin
                    if (y_up <= ApexS) begin
                        state_d = StHold;
                        y_d     = ApexY12;
                        hold_d  = HoldLoad;
                    end else begin
                        y_d = YWidth'(y_up);
                    end
                end
                StHold: begin
                    if (hold_q == '0) begin
                        state_d = StFall;
                    end else begin
                        hold_d = hold_q - 16'd1;
                    end
                end
                StFall: begin
                    if (y_dn >= GroundS) begin
                        state_d = StGround;
                        y_d     = GroundY12;
                    end else begin
                        y_d = YWidth'(y_dn);
                    end
                end
                default: begin
                    state_d = StGround;
                    y_d     = GroundY12;
                end
            endcase
        end
    end

    // Pending-jump flag and frame counter.
    always_comb begin
        pending_d = pending_q;
        fc_d      = fc_q;
        if (!enable) begin
            pending_d = 1'b0;
        end else begin
            // An edge arriving on a tick only counts toward the following tick,
            // because the tick looks at the registered pending_q.
            if (rise_pulse && (state_q == StGround)) begin
                pending_d = 1'b1;
            end
            if (tick && (state_q == StGround) && pending_q) begin
                pending_d = 1'b0;
            end
            if (tick) begin
                fc_d = fc_q + 32'd1;
            end
        end
    end

    // Outputs.
    always_comb begin
        airborne    = is_airborne(state_q);
        y_bottom    = y_q;
        frame_count = fc_q;
    end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
module tb_dino_jump_ctrl;

    localparam int G  = 400;
    localparam int JH = 120;
    localparam int F  = 4;
    localparam int H  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        screen_end;
    logic        jump_btn;
    logic        enable;
    logic [11:0] y_a, y_b;
    logic        air_a, air_b;
    logic [31:0] fc_a, fc_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: ticks since jump start per instance (0 = on ground).
    int          t_m[2];
    bit          pend_m[2];
    int          rstep_m[2];
    logic [31:0] fc_m;
    bit          prev_b;
    bit          en_m;

    typedef struct {
        int tick;
        int ya;
        bit aa;
        int yb;
        bit ab;
    } vec_t;
    vec_t tbl[15];

    int rec_ya[0:63];
    bit rec_aa[0:63];
    int rec_yb[0:63];
    bit rec_ab[0:63];

    always #5 clk = ~clk;

    dino_jump_ctrl u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .screen_end  (screen_end),
        .jump_btn    (jump_btn),
        .enable      (enable),
        .y_bottom    (y_a),
        .airborne    (air_a),
        .frame_count (fc_a)
    );

    dino_jump_ctrl #(.RISE_STEP(7)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .screen_end  (screen_end),
        .jump_btn    (jump_btn),
        .enable      (enable),
        .y_bottom    (y_b),
        .airborne    (air_b),
        .frame_count (fc_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_len(input int r);
        return (JH + r - 1) / r + H + (JH + F - 1) / F;
    endfunction

    // Trajectory as a closed-form function of ticks since the jump began.
    function automatic int model_y(input int t, input int r);
        int nr;
        int apex;
        int v;
        apex = G - JH;
        nr   = (JH + r - 1) / r;
        if (t == 0) return G;
        if (t <= nr) begin
            v = G - r * t;
            return (v < apex) ? apex : v;
        end
        if (t <= nr + H) return apex;
        v = apex + F * (t - nr - H);
        return (v > G) ? G : v;
    endfunction

    task automatic model_reset(input bit btn_level);
        for (int k = 0; k < 2; k++) begin
            t_m[k]    = 0;
            pend_m[k] = 1'b0;
        end
        fc_m   = '0;
        prev_b = btn_level;
    endtask

    task automatic model_tick();
        if (en_m) begin
            fc_m = fc_m + 32'd1;
            for (int k = 0; k < 2; k++) begin
                if (t_m[k] == 0) begin
                    if (pend_m[k]) begin
                        t_m[k]    = 1;
                        pend_m[k] = 1'b0;
                    end
                end else begin
                    t_m[k]++;
                    if (t_m[k] >= model_len(rstep_m[k])) t_m[k] = 0;
                end
            end
        end
    endtask

    task automatic check_frame();
        chk("y_a", 32'(y_a), 32'(model_y(t_m[0], rstep_m[0])));
        chk("air_a", 32'(air_a), 32'(t_m[0] != 0));
        chk("y_b", 32'(y_b), 32'(model_y(t_m[1], rstep_m[1])));
        chk("air_b", 32'(air_b), 32'(t_m[1] != 0));
        chk("fc_a", fc_a, fc_m);
        chk("fc_b", fc_b, fc_m);
    endtask

    // One frame: tick, then button level, then enable level, then check.
    task automatic run_frame(input bit b, input bit e);
        screen_end = 1'b1;
        step();
        screen_end = 1'b0;
        model_tick();
        jump_btn = b;
        if (b && !prev_b && en_m) begin
            for (int k = 0; k < 2; k++) if (t_m[k] == 0) pend_m[k] = 1'b1;
        end
        prev_b = b;
        repeat (6) step();
        enable = e;
        en_m   = e;
        if (!e) begin
            for (int k = 0; k < 2; k++) pend_m[k] = 1'b0;
        end
        repeat (3) step();
        check_frame();
        repeat (5) step();
    endtask

    initial begin
        logic [31:0] fc_frozen;
        bit          b;

        rstep_m[0] = 6;
        rstep_m[1] = 7;
        tbl[0]  = '{1,  394, 1, 393, 1};
        tbl[1]  = '{2,  388, 1, 386, 1};
        tbl[2]  = '{17, 298, 1, 281, 1};
        tbl[3]  = '{18, 292, 1, 280, 1};
        tbl[4]  = '{19, 286, 1, 280, 1};
        tbl[5]  = '{20, 280, 1, 280, 1};
        tbl[6]  = '{26, 280, 1, 280, 1};
        tbl[7]  = '{27, 280, 1, 284, 1};
        tbl[8]  = '{28, 280, 1, 288, 1};
        tbl[9]  = '{29, 284, 1, 292, 1};
        tbl[10] = '{55, 388, 1, 396, 1};
        tbl[11] = '{56, 392, 1, 400, 0};
        tbl[12] = '{57, 396, 1, 400, 0};
        tbl[13] = '{58, 400, 0, 400, 0};
        tbl[14] = '{62, 400, 0, 400, 0};

        screen_end = 1'b0;
        jump_btn   = 1'b0;
        enable     = 1'b1;
        en_m       = 1'b1;
        reset      = 1'b1;
        model_reset(1'b0);
        #1 reset = 1'b0;
        #1;
        chk("rst_y_a", 32'(y_a), 32'd400);
        chk("rst_air_a", 32'(air_a), 32'd0);
        chk("rst_fc_a", fc_a, 32'd0);
        chk("rst_y_b", 32'(y_b), 32'd400);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        step();
        step();

        // Five idle frames.
        repeat (5) run_frame(1'b0, 1'b1);
        chk("idle_y", 32'(y_a), 32'd400);
        chk("idle_air", 32'(air_a), 32'd0);
        chk("idle_fc", fc_a, 32'd5);

        // Edge reaching the pending flag on the same clock as a tick waits a tick.
        jump_btn = 1'b1;
        step();
        step();
        screen_end = 1'b1;
        step();
        screen_end = 1'b0;
        fc_m = fc_m + 32'd1;
        for (int k = 0; k < 2; k++) pend_m[k] = 1'b1;
        prev_b = 1'b1;
        repeat (3) step();
        chk("edge_tick_y", 32'(y_a), 32'd400);
        chk("edge_tick_air", 32'(air_a), 32'd0);
        run_frame(1'b1, 1'b1);
        chk("edge_next_y", 32'(y_a), 32'd394);
        repeat (60) run_frame(1'b0, 1'b1);

        // Single jump trajectory, with extra presses in RISE and in FALL.
        run_frame(1'b1, 1'b1);
        for (int k = 1; k <= 62; k++) begin
            b = (k < 3) || (k >= 5 && k < 10) || (k >= 40 && k < 45);
            run_frame(b, 1'b1);
            rec_ya[k] = int'(y_a);
            rec_aa[k] = air_a;
            rec_yb[k] = int'(y_b);
            rec_ab[k] = air_b;
        end
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("traj_y_a@%0d", tbl[i].tick), 32'(rec_ya[tbl[i].tick]), 32'(tbl[i].ya));
            chk($sformatf("traj_air_a@%0d", tbl[i].tick), 32'(rec_aa[tbl[i].tick]),
                32'(tbl[i].aa));
            chk($sformatf("traj_y_b@%0d", tbl[i].tick), 32'(rec_yb[tbl[i].tick]), 32'(tbl[i].yb));
            chk($sformatf("traj_air_b@%0d", tbl[i].tick), 32'(rec_ab[tbl[i].tick]),
                32'(tbl[i].ab));
        end

        // Freeze for ten ticks mid-RISE, then resume.
        run_frame(1'b1, 1'b1);
        repeat (5) run_frame(1'b1, 1'b1);
        run_frame(1'b1, 1'b0);
        chk("frz_start_y", 32'(y_a), 32'd364);
        fc_frozen = fc_m;
        repeat (9) run_frame(1'b1, 1'b0);
        run_frame(1'b1, 1'b1);
        chk("frz_y", 32'(y_a), 32'd364);
        chk("frz_fc", fc_a, fc_frozen);
        run_frame(1'b1, 1'b1);
        chk("frz_resume_y", 32'(y_a), 32'd358);
        repeat (60) run_frame(1'b0, 1'b1);

        // Asynchronous reset during FALL with the button held.
        run_frame(1'b0, 1'b1);
        run_frame(1'b1, 1'b1);
        repeat (33) run_frame(1'b1, 1'b1);
        chk("fall_y300", 32'(y_a), 32'd300);
        chk("fall_air", 32'(air_a), 32'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_y_a", 32'(y_a), 32'd400);
        chk("arst_air_a", 32'(air_a), 32'd0);
        chk("arst_fc_a", fc_a, 32'd0);
        chk("arst_y_b", 32'(y_b), 32'd400);
        chk("arst_air_b", 32'(air_b), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        model_reset(1'b1);
        step();
        step();
        repeat (4) run_frame(1'b1, 1'b1);
        chk("held_no_jump", 32'(y_a), 32'd400);
        run_frame(1'b0, 1'b1);
        run_frame(1'b1, 1'b1);
        run_frame(1'b0, 1'b1);
        chk("repress_jump", 32'(y_a), 32'd394);

        // Randomized frames against the model.
        repeat (250) begin
            run_frame(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
